// File: rtl/onchip_mem_stream_reader.sv
`default_nettype none
// ============================================================================
// Module   : onchip_mem_stream_reader
// Purpose  : Avalon-MM read master that streams a word range out as one
//            Avalon-ST packet through a small credit-managed skid FIFO.
// Revision : 1.0
// ============================================================================
module onchip_mem_stream_reader #(
    parameter int ADDR_W       = 15,
    parameter int DATA_W       = 32,
    parameter int READ_LATENCY = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                start,
    input  logic [ADDR_W-1:0]   base_addr,
    input  logic [ADDR_W:0]     length,
    output logic                busy,
    output logic                done,
    output logic [ADDR_W-1:0]   mm_address,
    output logic                mm_chipselect,
    output logic                mm_write,
    output logic [DATA_W/8-1:0] mm_byteenable,
    output logic                mm_clken,
    input  logic [DATA_W-1:0]   mm_readdata,
    output logic [DATA_W-1:0]   st_data,
    output logic                st_valid,
    input  logic                st_ready,
    output logic                st_startofpacket,
    output logic                st_endofpacket
);

    localparam int c_ptr_w = $clog2(FIFO_DEPTH);
    localparam int c_cnt_w = c_ptr_w + 1;
    localparam int c_sum_w = c_cnt_w + 1;
    localparam int c_len_w = ADDR_W + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t                  r_state;
    logic [DATA_W-1:0]       r_fifo_mem [FIFO_DEPTH];
    logic [c_ptr_w-1:0]      r_wr_ptr;
    logic [c_ptr_w-1:0]      r_rd_ptr;
    logic [c_cnt_w-1:0]      r_count;
    logic [READ_LATENCY-1:0] r_sr;
    logic                    r_cs;
    logic [ADDR_W-1:0]       r_addr;
    logic [c_len_w-1:0]      r_issue_cnt;
    logic [c_len_w-1:0]      r_beat_cnt;
    logic [c_len_w-1:0]      r_len;
    logic                    r_busy;
    logic                    r_done;

    logic                    w_push;
    logic                    w_pop;
    logic [c_cnt_w-1:0]      w_count_next;
    logic [READ_LATENCY-1:0] w_sr_next;
    logic [c_sum_w-1:0]      w_inflight_next;
    logic [c_len_w-1:0]      w_issue_left;
    logic                    w_credit;

    assign mm_write         = 1'b0;
    assign mm_byteenable    = '1;
    assign mm_clken         = 1'b1;
    assign mm_address       = r_addr;
    assign mm_chipselect    = r_cs;
    assign busy             = r_busy;
    assign done             = r_done;
    assign st_valid         = (r_count != '0);
    assign st_data          = r_fifo_mem[r_rd_ptr];
    assign st_startofpacket = st_valid && (r_beat_cnt == r_len);
    assign st_endofpacket   = st_valid && (r_beat_cnt == c_len_w'(1));

    assign w_push       = r_sr[READ_LATENCY-1];
    assign w_pop        = st_valid && st_ready;
    assign w_count_next = r_count + c_cnt_w'(w_push) - c_cnt_w'(w_pop);
    assign w_issue_left = r_issue_cnt - c_len_w'(r_cs);

    generate
        if (READ_LATENCY == 1) begin : g_sr_single
            assign w_sr_next = r_cs;
        end else begin : g_sr_multi
            assign w_sr_next = {r_sr[READ_LATENCY-2:0], r_cs};
        end
    endgenerate

    always_comb begin
        w_inflight_next = '0;
        for (int i = 0; i < READ_LATENCY; i++) begin
            w_inflight_next = w_inflight_next + c_sum_w'(w_sr_next[i]);
        end
    end

    // Decide next cycle's strobe from next-cycle occupancy so the slot is never oversubscribed.
    assign w_credit = (c_sum_w'(w_count_next) + w_inflight_next) < c_sum_w'(FIFO_DEPTH);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_sr        <= '0;
            r_cs        <= 1'b0;
            r_addr      <= '0;
            r_issue_cnt <= '0;
            r_beat_cnt  <= '0;
            r_len       <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_fifo_mem[i] <= '0;
            end
        end else begin
            r_done  <= 1'b0;
            r_sr    <= w_sr_next;
            r_count <= w_count_next;
            if (w_push) begin
                r_fifo_mem[r_wr_ptr] <= mm_readdata;
                r_wr_ptr             <= r_wr_ptr + c_ptr_w'(1);
            end
            if (w_pop) begin
                r_rd_ptr   <= r_rd_ptr + c_ptr_w'(1);
                r_beat_cnt <= r_beat_cnt - c_len_w'(1);
            end

            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        if (length != '0) begin
                            r_len       <= length;
                            r_issue_cnt <= length;
                            r_beat_cnt  <= length;
                            r_addr      <= base_addr;
                            r_cs        <= 1'b1;
                            r_busy      <= 1'b1;
                            r_state     <= S_RUN;
                        end else begin
                            r_done <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    if (r_cs) begin
                        r_addr <= r_addr + ADDR_W'(1);
                    end
                    r_issue_cnt <= w_issue_left;
                    if (w_issue_left == '0) begin
                        r_cs    <= 1'b0;
                        r_state <= S_DRAIN;
                    end else begin
                        r_cs <= w_credit;
                    end
                end
                S_DRAIN: begin
                    if (w_pop && st_endofpacket) begin
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_onchip_mem_stream_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_onchip_mem_stream_reader
// Purpose  : Directed, table-driven bench for onchip_mem_stream_reader.
// Revision : 1.0
// ============================================================================
module tb_onchip_mem_stream_reader;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [14:0] base_addr = '0;
    logic [15:0] length = '0;
    logic        busy, done;
    logic [14:0] mm_address;
    logic        mm_chipselect, mm_write, mm_clken;
    logic [3:0]  mm_byteenable;
    logic [31:0] mm_readdata = '0;
    logic [31:0] st_data;
    logic        st_valid, st_startofpacket, st_endofpacket;
    logic        st_ready = 1'b1;

    int errors = 0;
    int checks = 0;

    onchip_mem_stream_reader dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .start            (start),
        .base_addr        (base_addr),
        .length           (length),
        .busy             (busy),
        .done             (done),
        .mm_address       (mm_address),
        .mm_chipselect    (mm_chipselect),
        .mm_write         (mm_write),
        .mm_byteenable    (mm_byteenable),
        .mm_clken         (mm_clken),
        .mm_readdata      (mm_readdata),
        .st_data          (st_data),
        .st_valid         (st_valid),
        .st_ready         (st_ready),
        .st_startofpacket (st_startofpacket),
        .st_endofpacket   (st_endofpacket)
    );

    always #5 clk = ~clk;

    // Memory preloaded with mem[a] = a * 0x00010001, one cycle read latency.
    function automatic logic [31:0] mem_word(input logic [14:0] a);
        return {1'b0, a, 1'b0, a};
    endfunction

    always @(posedge clk) begin
        if (mm_chipselect) mm_readdata <= mem_word(mm_address);
        else               mm_readdata <= 32'hDEAD_BEEF;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [14:0] base;
        logic [15:0] len;
        int          stall_lo;
        int          stall_hi;
        int          restart_cyc;
        int          exp_done;
    } vec_t;

    task automatic run_packet(input vec_t v);
        int issues, beats, done_cyc, done_cnt, budget;
        int addr_err, data_err, flag_err, hold_err, busy_err, max_out;
        logic [14:0] exp_addr;
        logic        prev_stall, prev_sop, prev_eop, rdy, exp_busy;
        logic [31:0] prev_data;
        issues = 0; beats = 0; done_cyc = -1; done_cnt = 0;
        addr_err = 0; data_err = 0; flag_err = 0; hold_err = 0; busy_err = 0; max_out = 0;
        prev_stall = 1'b0; prev_sop = 1'b0; prev_eop = 1'b0; prev_data = '0;
        budget = int'(v.len) + 80;
        @(negedge clk);
        start = 1'b1; base_addr = v.base; length = v.len; st_ready = 1'b1;
        for (int c = 1; c <= budget && done_cyc < 0; c++) begin
            @(negedge clk);
            start = (c == v.restart_cyc);
            base_addr = 15'h5A5A;
            length = 16'd2;
            rdy = !(c >= v.stall_lo && c <= v.stall_hi);
            st_ready = rdy;
            if (mm_chipselect) begin
                exp_addr = v.base + 15'(issues);
                if (mm_address !== exp_addr) addr_err++;
                issues++;
            end
            if (issues - beats > max_out) max_out = issues - beats;
            exp_busy = (v.len != 0) && !done;
            if (busy !== exp_busy) busy_err++;
            if (prev_stall && (st_valid !== 1'b1 || st_data !== prev_data ||
                               st_startofpacket !== prev_sop || st_endofpacket !== prev_eop))
                hold_err++;
            if (st_valid && rdy) begin
                exp_addr = v.base + 15'(beats);
                if (st_data !== mem_word(exp_addr)) data_err++;
                if (st_startofpacket !== (beats == 0) ||
                    st_endofpacket !== (beats == int'(v.len) - 1)) flag_err++;
                beats++;
            end
            prev_stall = st_valid && !rdy;
            prev_data = st_data; prev_sop = st_startofpacket; prev_eop = st_endofpacket;
            if (done) begin
                done_cyc = c;
                done_cnt++;
            end
        end
        @(negedge clk);
        start = 1'b0;
        st_ready = 1'b1;
        check("done_cycle", done_cyc, v.exp_done);
        check("issue_count", issues, int'(v.len));
        check("beat_count", beats, int'(v.len));
        check("addr_errors", addr_err, 0);
        check("data_errors", data_err, 0);
        check("sop_eop_errors", flag_err, 0);
        check("hold_errors", hold_err, 0);
        check("busy_errors", busy_err, 0);
        check("outstanding_le_4", max_out <= 4, 1);
        check("done_count", done_cnt, 1);
        check("done_one_pulse", {done, busy, st_valid, mm_chipselect}, 4'b0000);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_cs"}, mm_chipselect, 0);
        check({tag, "_addr"}, mm_address, 0);
        check({tag, "_valid"}, st_valid, 0);
        check({tag, "_sop_eop"}, {st_startofpacket, st_endofpacket}, 0);
        check({tag, "_data"}, st_data, 0);
    endtask

    vec_t vecs[7];
    int   quiet_err;

    initial begin
        //          base      len        stall lo/hi  restart  done
        vecs[0] = '{15'h0010, 16'd4,     0, -1,       -1,      7};
        vecs[1] = '{15'h7FFE, 16'd4,     0, -1,       -1,      7};
        vecs[2] = '{15'h0100, 16'd1,     0, -1,       -1,      4};
        vecs[3] = '{15'h0000, 16'd0,     0, -1,       -1,      1};
        vecs[4] = '{15'h0020, 16'd16,    5, 20,       -1,      35};
        vecs[5] = '{15'h0040, 16'd4,     0, -1,       2,       7};
        vecs[6] = '{15'h0000, 16'h8000,  0, -1,       -1,      32771};

        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        check("const_outputs", {mm_write, mm_clken, mm_byteenable}, 6'b0_1_1111);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 6; i++) run_packet(vecs[i]);

        // Abort mid-packet with a two-cycle reset, then confirm silence.
        @(negedge clk);
        start = 1'b1; base_addr = 15'h0200; length = 16'd8;
        repeat (3) begin
            @(negedge clk);
            start = 1'b0;
        end
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check_reset_outputs("abort");
        @(negedge clk);
        #1;
        check_reset_outputs("abort_hold");
        @(negedge clk);
        reset_n = 1'b1;
        quiet_err = 0;
        repeat (10) begin
            @(negedge clk);
            if (done || mm_chipselect || st_valid || busy) quiet_err++;
        end
        check("post_abort_quiet", quiet_err, 0);

        run_packet('{15'h0300, 16'd3, 0, -1, -1, 6});
        run_packet(vecs[6]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
